pipe_stage_buf: RTL

//  Parametrised pipeline stage register: the next generation of our fixed-field stage latches.

---
 rtl/pipe_stage_buf.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register with hazard STALL/FLUSH (FLUSH dominant) and optional 2-entry skid.
// Latency 1 cycle; SKID=1 gives a registered IN_READY at full throughput, SKID=0 a combinational one.
module pipe_stage_buf #(
    parameter int DATA_W         = 32,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  BUBBLE_COUNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, stateNxt;
    logic [DATA_W-1:0] mainData, mainNxt;
    logic [DATA_W-1:0] skidData, skidNxt;
    logic              outValidQ, inReadyQ;
    logic              inReadyInt, inXfer, outXfer, bubble;
    logic [CNT_W-1:0]  bubbleCnt;

    assign outXfer    = outValidQ & OUT_READY & ~STALL;
    assign inReadyInt = (SKID != 0) ? inReadyQ : (~outValidQ | (OUT_READY & ~STALL));
    assign inXfer     = IN_VALID & inReadyInt & ~FLUSH;
    assign bubble     = OUT_READY & ~STALL & ~outValidQ;

    always_comb begin
        stateNxt = state;
        mainNxt  = mainData;
        skidNxt  = skidData;
        if (FLUSH) begin
            stateNxt = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                mainNxt = '0;
                skidNxt = '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (inXfer) begin
                        stateNxt = ONE;
                        mainNxt  = IN_DATA;
                    end
                end
                ONE: begin
                    // SKID=0 can only accept while ONE when the head leaves in the same cycle.
                    if (inXfer && outXfer) begin
                        mainNxt = IN_DATA;
                    end else if (inXfer && (SKID != 0)) begin
                        stateNxt = FULL;
                        skidNxt  = IN_DATA;
                    end else if (outXfer) begin
                        stateNxt = EMPTY;
                    end
                end
                FULL: begin
                    if (outXfer) begin
                        stateNxt = ONE;
                        mainNxt  = skidData;
                    end
                end
                default: stateNxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= EMPTY;
            mainData  <= '0;
            skidData  <= '0;
            outValidQ <= 1'b0;
            inReadyQ  <= 1'b1;
        end else begin
            state     <= stateNxt;
            mainData  <= mainNxt;
            skidData  <= skidNxt;
            outValidQ <= (stateNxt != EMPTY);
            inReadyQ  <= (stateNxt != FULL);
        end
    end

    // Saturating; FLUSH deliberately has no effect on the statistic.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            bubbleCnt <= '0;
        end else if (bubble && (bubbleCnt != {CNT_W{1'b1}})) begin
            bubbleCnt <= bubbleCnt + CNT_W'(1);
        end
    end

    assign IN_READY     = inReadyInt;
    assign OUT_VALID    = outValidQ;
    assign OUT_DATA     = mainData;
    assign OCCUPANCY    = state;
    assign BUBBLE_COUNT = bubbleCnt;

endmodule
